// File: rtl/ppi_pkg.sv
// ============================================================================
//  Module   : ppi_pkg
//  Purpose  : Shared constants for the 8255-style PPI bus-control slice.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ppi_pkg;

  localparam logic [1:0] ADDR_PA   = 2'd0;
  localparam logic [1:0] ADDR_PB   = 2'd1;
  localparam logic [1:0] ADDR_PC   = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int CW_FLAG = 7;
  localparam int CW_PA   = 4;
  localparam int CW_PCU  = 3;
  localparam int CW_PB   = 1;
  localparam int CW_PCL  = 0;

  localparam logic [7:0] CTRL_RST_DEF  = 8'h9B;
  localparam logic [7:0] READ_CTRL_VAL = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/ppi_bus_control_sync.sv
// ============================================================================
//  Module   : ppi_strobe_sync
//  Purpose  : Optional input synchronizer (PPI_BUS_SYNC_EN), access
//             qualification and registered write falling-edge detect.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ppi_strobe_sync #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs_n,
  input  logic          rd_n,
  input  logic          wr_n,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] din,
  output logic          wr_cap,
  output logic          wr_commit,
  output logic          rd_act,
  output logic [1:0]    addr_s,
  output logic [DW-1:0] din_s
);

  logic w_cs_n;
  logic w_rd_n;
  logic w_wr_n;
  logic w_wr_act;
  logic r_armed;
  logic r_wr_d;

`ifdef PPI_BUS_SYNC_EN
  logic [1:0]    r_cs_n_sync;
  logic [1:0]    r_rd_n_sync;
  logic [1:0]    r_wr_n_sync;
  logic [1:0]    r_addr_s1;
  logic [1:0]    r_addr_s2;
  logic [DW-1:0] r_din_s1;
  logic [DW-1:0] r_din_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs_n_sync <= 2'b11;
      r_rd_n_sync <= 2'b11;
      r_wr_n_sync <= 2'b11;
      r_addr_s1   <= '0;
      r_addr_s2   <= '0;
      r_din_s1    <= '0;
      r_din_s2    <= '0;
    end else begin
      r_cs_n_sync <= {r_cs_n_sync[0], cs_n};
      r_rd_n_sync <= {r_rd_n_sync[0], rd_n};
      r_wr_n_sync <= {r_wr_n_sync[0], wr_n};
      r_addr_s1   <= addr;
      r_addr_s2   <= r_addr_s1;
      r_din_s1    <= din;
      r_din_s2    <= r_din_s1;
    end
  end

  assign w_cs_n = r_cs_n_sync[1];
  assign w_rd_n = r_rd_n_sync[1];
  assign w_wr_n = r_wr_n_sync[1];
  assign addr_s = r_addr_s2;
  assign din_s  = r_din_s2;
`else
  assign w_cs_n = cs_n;
  assign w_rd_n = rd_n;
  assign w_wr_n = wr_n;
  assign addr_s = addr;
  assign din_s  = din;
`endif

  assign w_wr_act = ~w_cs_n & ~w_wr_n;
  assign rd_act   = ~w_cs_n & ~w_rd_n & ~w_wr_act;

  // Writes only count once an idle sample has been seen since reset, so a
  // strobe straddling reset release can never produce a commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed <= 1'b0;
      r_wr_d  <= 1'b0;
    end else begin
      r_armed <= r_armed | ~w_wr_act;
      r_wr_d  <= w_wr_act & r_armed;
    end
  end

  assign wr_cap    = w_wr_act & r_armed;
  assign wr_commit = r_wr_d & ~w_wr_act;

endmodule

`default_nettype wire

// File: rtl/ppi_bus_control.sv
// ============================================================================
//  Module   : ppi_bus_control
//  Purpose  : PPI CPU-side read/write control, control word and port latches
//             (mode 0). Optional input synchronizer: PPI_BUS_SYNC_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ppi_bus_control
  import ppi_pkg::*;
#(
  parameter int            DW       = 8,
  parameter logic [DW-1:0] CTRL_RST = DW'(CTRL_RST_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs_n,
  input  logic          rd_n,
  input  logic          wr_n,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dout_en,
  input  logic [DW-1:0] pa_in,
  input  logic [DW-1:0] pb_in,
  input  logic [DW-1:0] pc_in,
  output logic [DW-1:0] pa_out,
  output logic [DW-1:0] pb_out,
  output logic [DW-1:0] pc_out,
  output logic          pa_mode,
  output logic          pb_mode,
  output logic          pcu_mode,
  output logic          pcl_mode,
  output logic          pa_en,
  output logic          pb_en,
  output logic          pc_en
);

  logic          w_wr_cap;
  logic          w_wr_commit;
  logic          w_rd_act;
  logic [1:0]    w_addr;
  logic [DW-1:0] w_din;
  logic [DW-1:0] w_rd_data;
  logic          w_unused_ctrl;

  logic [DW-1:0] r_ctrl;
  logic [DW-1:0] r_pa_out;
  logic [DW-1:0] r_pb_out;
  logic [DW-1:0] r_pc_out;
  logic [1:0]    r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic [DW-1:0] r_dout;
  logic          r_dout_en;
  logic          r_pa_en;
  logic          r_pb_en;
  logic          r_pc_en;

  ppi_strobe_sync #(.DW(DW)) u_strobe_sync (
    .clk       (clk),
    .reset     (reset),
    .cs_n      (cs_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .addr      (addr),
    .din       (din),
    .wr_cap    (w_wr_cap),
    .wr_commit (w_wr_commit),
    .rd_act    (w_rd_act),
    .addr_s    (w_addr),
    .din_s     (w_din)
  );

  always_comb begin
    w_rd_data = DW'(READ_CTRL_VAL);
    case (w_addr)
      ADDR_PA: w_rd_data = r_ctrl[CW_PA] ? pa_in : r_pa_out;
      ADDR_PB: w_rd_data = r_ctrl[CW_PB] ? pb_in : r_pb_out;
      ADDR_PC: w_rd_data = {r_ctrl[CW_PCU] ? pc_in[DW-1:DW/2]  : r_pc_out[DW-1:DW/2],
                            r_ctrl[CW_PCL] ? pc_in[DW/2-1:0]   : r_pc_out[DW/2-1:0]};
      default: w_rd_data = DW'(READ_CTRL_VAL);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl    <= CTRL_RST;
      r_pa_out  <= '0;
      r_pb_out  <= '0;
      r_pc_out  <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_dout    <= '0;
      r_dout_en <= 1'b0;
      r_pa_en   <= 1'b0;
      r_pb_en   <= 1'b0;
      r_pc_en   <= 1'b0;
    end else begin
      if (w_wr_cap) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_din;
      end

      // Port latches load regardless of direction; mode set clears them all.
      if (w_wr_commit) begin
        case (r_wr_addr)
          ADDR_PA: r_pa_out <= r_wr_data;
          ADDR_PB: r_pb_out <= r_wr_data;
          ADDR_PC: r_pc_out <= r_wr_data;
          default: begin
            if (r_wr_data[CW_FLAG]) begin
              r_ctrl   <= r_wr_data;
              r_pa_out <= '0;
              r_pb_out <= '0;
              r_pc_out <= '0;
            end else begin
              r_pc_out[r_wr_data[3:1]] <= r_wr_data[0];
            end
          end
        endcase
      end

      r_dout_en <= w_rd_act;
      if (w_rd_act) begin
        r_dout <= w_rd_data;
      end

      r_pa_en <= ~r_ctrl[CW_PA] | (w_rd_act && (w_addr == ADDR_PA));
      r_pb_en <= ~r_ctrl[CW_PB] | (w_rd_act && (w_addr == ADDR_PB));
      r_pc_en <= ~r_ctrl[CW_PCU] | ~r_ctrl[CW_PCL] | (w_rd_act && (w_addr == ADDR_PC));
    end
  end

  // Mode-select bits are stored but have no effect in mode-0-only operation.
  assign w_unused_ctrl = &{1'b0, r_ctrl[CW_FLAG:CW_PA+1], r_ctrl[CW_PB+1]};

  assign dout     = r_dout;
  assign dout_en  = r_dout_en;
  assign pa_out   = r_pa_out;
  assign pb_out   = r_pb_out;
  assign pc_out   = r_pc_out;
  assign pa_mode  = r_ctrl[CW_PA];
  assign pb_mode  = r_ctrl[CW_PB];
  assign pcu_mode = r_ctrl[CW_PCU];
  assign pcl_mode = r_ctrl[CW_PCL];
  assign pa_en    = r_pa_en;
  assign pb_en    = r_pb_en;
  assign pc_en    = r_pc_en;

endmodule

`default_nettype wire
